// File: rtl/game_pkg.sv
// Shared types and widths for the pong frame-step sequencer.
package game_pkg;

    localparam int unsigned SPEED_W = 4;
    localparam int unsigned LIVES_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        SERVE,
        WAIT_FRAME,
        PADDLE,
        BALL,
        CHECK,
        OVER
    } seq_state_t;

endpackage

// File: rtl/game_speed_ramp.sv
// Ball speed ramp: counts paddle hits and bumps speed every HITS_PER_SPEEDUP hits, saturating at SPEED_MAX.
module game_speed_ramp
    import game_pkg::*;
#(
    parameter int unsigned HITS_PER_SPEEDUP = 4,
    parameter int unsigned SPEED_INIT       = 1,
    parameter int unsigned SPEED_MAX        = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               hit_strobe,
    output logic [SPEED_W-1:0] ball_speed
);

    logic [3:0] hit_cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            hit_cnt    <= '0;
            ball_speed <= SPEED_W'(SPEED_INIT);
        end else if (hit_strobe) begin
            if (({1'b0, hit_cnt} + 5'd1) == 5'(HITS_PER_SPEEDUP)) begin
                hit_cnt <= '0;
                if (ball_speed < SPEED_W'(SPEED_MAX))
                    ball_speed <= ball_speed + 4'd1;
            end else begin
                hit_cnt <= hit_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/game_step_sequencer.sv
// Per-frame paddle/ball/check sequencer with serve delay, lives and game-over latch.
// Speed ramp is present only when GAME_SEQ_SPEEDUP_EN is defined; otherwise ball_speed is SPEED_INIT.
module game_step_sequencer
    import game_pkg::*;
#(
    parameter int unsigned FRAME_DIV        = 1,
    parameter int unsigned SERVE_FRAMES     = 60,
    parameter int unsigned HITS_PER_SPEEDUP = 4,
    parameter int unsigned SPEED_INIT       = 1,
    parameter int unsigned SPEED_MAX        = 6,
    parameter int unsigned LIVES            = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               frame_start,
    input  logic               hit,
    input  logic               miss,
    output logic               paddle_step,
    output logic               ball_step,
    output logic [SPEED_W-1:0] ball_speed,
    output logic               serve_hold,
    output logic [LIVES_W-1:0] lives,
    output logic               game_over
);

    seq_state_t         state, state_nxt;
    logic [7:0]         serve_cnt, serve_nxt;
    logic [3:0]         frame_cnt, frame_nxt;
    logic [LIVES_W-1:0] lives_nxt;
    logic               paddle_nxt;
    logic               speed_clear;
    logic               hit_strobe;

    always_comb begin
        state_nxt   = state;
        serve_nxt   = serve_cnt;
        frame_nxt   = frame_cnt;
        lives_nxt   = lives;
        paddle_nxt  = 1'b0;
        speed_clear = 1'b0;
        hit_strobe  = 1'b0;

        case (state)
            IDLE: begin
                if (run) begin
                    state_nxt = SERVE;
                    serve_nxt = 8'(SERVE_FRAMES);
                end
            end
            SERVE: begin
                if (serve_cnt == '0) begin
                    state_nxt = WAIT_FRAME;
                    frame_nxt = '0;
                end else if (frame_start) begin
                    paddle_nxt = 1'b1;
                    serve_nxt  = serve_cnt - 8'd1;
                end
            end
            WAIT_FRAME: begin
                if (frame_start)
                    state_nxt = PADDLE;
            end
            PADDLE: begin
                if (frame_cnt == 4'(FRAME_DIV - 1)) begin
                    frame_nxt = '0;
                    state_nxt = BALL;
                end else begin
                    frame_nxt = frame_cnt + 4'd1;
                    state_nxt = WAIT_FRAME;
                end
            end
            BALL: state_nxt = CHECK;
            CHECK: begin
                // miss takes priority; a simultaneous hit must not advance the ramp
                if (miss) begin
                    if (lives > LIVES_W'(1)) begin
                        lives_nxt   = lives - LIVES_W'(1);
                        speed_clear = 1'b1;
                        serve_nxt   = 8'(SERVE_FRAMES);
                        state_nxt   = SERVE;
                    end else begin
                        lives_nxt = '0;
                        state_nxt = OVER;
                    end
                end else begin
                    hit_strobe = hit;
                    state_nxt  = WAIT_FRAME;
                end
            end
            OVER: begin
                if (!run) begin
                    state_nxt   = IDLE;
                    lives_nxt   = LIVES_W'(LIVES);
                    speed_clear = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (!run && state != OVER) begin
            state_nxt   = IDLE;
            serve_nxt   = '0;
            frame_nxt   = '0;
            lives_nxt   = LIVES_W'(LIVES);
            paddle_nxt  = 1'b0;
            speed_clear = 1'b1;
            hit_strobe  = 1'b0;
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            serve_cnt   <= '0;
            frame_cnt   <= '0;
            lives       <= LIVES_W'(LIVES);
            paddle_step <= 1'b0;
            ball_step   <= 1'b0;
            serve_hold  <= 1'b1;
            game_over   <= 1'b0;
        end else begin
            state       <= state_nxt;
            serve_cnt   <= serve_nxt;
            frame_cnt   <= frame_nxt;
            lives       <= lives_nxt;
            paddle_step <= paddle_nxt || (state_nxt == PADDLE);
            ball_step   <= (state_nxt == BALL);
            serve_hold  <= (state_nxt == IDLE) || (state_nxt == SERVE) || (state_nxt == OVER);
            game_over   <= (state_nxt == OVER);
        end
    end

`ifdef GAME_SEQ_SPEEDUP_EN
    game_speed_ramp #(
        .HITS_PER_SPEEDUP (HITS_PER_SPEEDUP),
        .SPEED_INIT       (SPEED_INIT),
        .SPEED_MAX        (SPEED_MAX)
    ) u_speed_ramp (
        .clk        (clk),
        .reset      (reset),
        .clear      (speed_clear),
        .hit_strobe (hit_strobe),
        .ball_speed (ball_speed)
    );
`else
    logic unused_ramp;
    assign unused_ramp = hit_strobe ^ speed_clear ^ (HITS_PER_SPEEDUP == 0) ^ (SPEED_MAX == 0);
    assign ball_speed  = SPEED_W'(SPEED_INIT);
`endif

endmodule

// File: tb/tb_game_step_sequencer.sv
// Randomized bench for game_step_sequencer against a game-level reference model.
module tb_game_step_sequencer;

    localparam int unsigned FRAME_DIV        = 2;
    localparam int unsigned SERVE_FRAMES     = 3;
    localparam int unsigned HITS_PER_SPEEDUP = 2;
    localparam int unsigned SPEED_INIT       = 1;
    localparam int unsigned SPEED_MAX        = 3;
    localparam int unsigned LIVES            = 3;

    localparam int MODE_IDLE  = 0;
    localparam int MODE_SERVE = 1;
    localparam int MODE_PLAY  = 2;
    localparam int MODE_OVER  = 3;

    logic       clk = 1'b0;
    logic       reset, run, frame_start, hit, miss;
    logic       paddle_step, ball_step, serve_hold, game_over;
    logic [3:0] ball_speed;
    logic [1:0] lives;

    int errors = 0;
    int checks = 0;

    // reference model: game mode plus cycles elapsed since an accepted frame
    int m_mode, m_stage, m_frames, m_serve_left, m_hits, m_speed, m_lives;
    int e_paddle, e_ball, e_hold, e_over;

    game_step_sequencer #(
        .FRAME_DIV        (FRAME_DIV),
        .SERVE_FRAMES     (SERVE_FRAMES),
        .HITS_PER_SPEEDUP (HITS_PER_SPEEDUP),
        .SPEED_INIT       (SPEED_INIT),
        .SPEED_MAX        (SPEED_MAX),
        .LIVES            (LIVES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .frame_start (frame_start),
        .hit         (hit),
        .miss        (miss),
        .paddle_step (paddle_step),
        .ball_step   (ball_step),
        .ball_speed  (ball_speed),
        .serve_hold  (serve_hold),
        .lives       (lives),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic rst, input logic r, input logic fs,
                              input logic h, input logic m);
        e_paddle = 0;
        if (rst || (!r && m_mode != MODE_OVER)) begin
            m_mode = MODE_IDLE; m_stage = 0; m_frames = 0; m_serve_left = 0;
            m_hits = 0; m_speed = SPEED_INIT; m_lives = LIVES;
        end else begin
            case (m_mode)
                MODE_IDLE: begin
                    m_mode = MODE_SERVE;
                    m_serve_left = SERVE_FRAMES;
                end
                MODE_SERVE: begin
                    if (m_serve_left == 0) begin
                        m_mode = MODE_PLAY; m_stage = 0; m_frames = 0;
                    end else if (fs) begin
                        e_paddle = 1;
                        m_serve_left--;
                    end
                end
                MODE_PLAY: begin
                    case (m_stage)
                        0: if (fs) m_stage = 1;
                        1: begin
                            m_frames++;
                            if (m_frames == FRAME_DIV) begin
                                m_frames = 0; m_stage = 2;
                            end else begin
                                m_stage = 0;
                            end
                        end
                        2: m_stage = 3;
                        default: begin
                            m_stage = 0;
                            if (m) begin
                                if (m_lives > 1) begin
                                    m_lives--; m_speed = SPEED_INIT; m_hits = 0;
                                    m_mode = MODE_SERVE; m_serve_left = SERVE_FRAMES;
                                end else begin
                                    m_lives = 0; m_mode = MODE_OVER;
                                end
                            end else if (h) begin
                                m_hits++;
                                if (m_hits == HITS_PER_SPEEDUP) begin
                                    m_hits = 0;
`ifdef GAME_SEQ_SPEEDUP_EN
                                    if (m_speed < SPEED_MAX) m_speed++;
`endif
                                end
                            end
                        end
                    endcase
                end
                default: begin
                    if (!r) begin
                        m_mode = MODE_IDLE; m_lives = LIVES; m_speed = SPEED_INIT; m_hits = 0;
                    end
                end
            endcase
        end
        if (m_mode == MODE_PLAY && m_stage == 1) e_paddle = 1;
        e_ball = (m_mode == MODE_PLAY && m_stage == 2) ? 1 : 0;
        e_hold = (m_mode != MODE_PLAY) ? 1 : 0;
        e_over = (m_mode == MODE_OVER) ? 1 : 0;
    endtask

    task automatic cycle(input logic rst, input logic r, input logic fs,
                         input logic h, input logic m);
        reset = rst; run = r; frame_start = fs; hit = h; miss = m;
        @(posedge clk);
        model_step(rst, r, fs, h, m);
        #1;
        check_val("paddle_step", int'(paddle_step), e_paddle);
        check_val("ball_step",   int'(ball_step),   e_ball);
        check_val("serve_hold",  int'(serve_hold),  e_hold);
        check_val("game_over",   int'(game_over),   e_over);
        check_val("lives",       int'(lives),       m_lives);
        check_val("ball_speed",  int'(ball_speed),  m_speed);
    endtask

    initial begin
        int run_low;
        m_mode = MODE_IDLE; m_stage = 0; m_frames = 0; m_serve_left = 0;
        m_hits = 0; m_speed = SPEED_INIT; m_lives = LIVES;
        reset = 1'b1; run = 1'b0; frame_start = 1'b0; hit = 1'b0; miss = 1'b0;

        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // serve then steady play with frames every 10 cycles and a hit in every cycle
        for (int i = 0; i < 200; i++)
            cycle(1'b0, 1'b1, (i % 10) == 9, 1'b1, 1'b0);

        // three consecutive misses drive the game to its end, then release run
        for (int i = 0; i < 400; i++)
            cycle(1'b0, 1'b1, (i % 10) == 9, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        run_low = 0;
        for (int i = 0; i < 6000; i++) begin
            logic r, fs, h, m, rst;
            if (run_low == 0 && $urandom_range(0, 299) == 0)
                run_low = $urandom_range(1, 3);
            r = (run_low == 0);
            if (run_low > 0) run_low--;
            fs  = ($urandom_range(0, 3) == 0);
            h   = ($urandom_range(0, 1) == 0);
            m   = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 1999) == 0);
            cycle(rst, r, fs, h, m);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
